// File: rtl/iic_cfg_sequencer_if.sv
// rtl/iic_cfg_sequencer_if.sv - transfer request/handshake bundle between the sequencer and iic_send
`timescale 1ns/1ps
interface iic_cfg_sequencer_if;
   logic       iic_send_en;
   logic [6:0] dev_addr;
   logic [7:0] word_addr;
   logic [7:0] write_data;
   logic       iic_done;

   modport master (output iic_send_en, dev_addr, word_addr, write_data, input iic_done);
   modport slave  (input iic_send_en, dev_addr, word_addr, write_data, output iic_done);
endinterface

// File: rtl/iic_cfg_sequencer.sv
// rtl/iic_cfg_sequencer.sv - walks a register ROM and issues one iic_send write per entry
`timescale 1ns/1ps
module iic_cfg_sequencer #(
   parameter logic [6:0]  C_DEV_ADDR   = 7'h21,
   parameter logic [7:0]  C_REG_NUM    = 8'd16,
   parameter logic [31:0] C_TIMEOUT    = 32'd50000,
   parameter logic [3:0]  C_RETRY_MAX  = 4'd3,
   parameter logic [15:0] C_GAP_CYCLES = 16'd1000
) (
   input  logic                 I_clk,
   input  logic                 I_rst_n,
   input  logic                 I_start,
   output logic [7:0]           O_rom_addr,
   input  logic [15:0]          I_rom_data,
   iic_cfg_sequencer_if.master  iic,
   output logic                 O_busy,
   output logic                 O_cfg_done,
   output logic                 O_cfg_err,
   output logic [7:0]           O_err_index
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH_ADDR, S_FETCH_DATA, S_SEND, S_GAP, S_DONE, S_ERR
   } state_t;

   state_t      state, state_nxt;
   logic [8:0]  index, index_nxt;
   logic [3:0]  retry, retry_nxt;
   logic [31:0] cnt, cnt_nxt;
   logic [7:0]  rom_addr_nxt, word_q, word_nxt, data_q, data_nxt, err_index_nxt;
   logic        cfg_done_nxt, cfg_err_nxt;

   // Enable is a pure state decode so an async reset drops it in the same instant.
   assign iic.iic_send_en = (state == S_SEND);
   assign iic.dev_addr    = C_DEV_ADDR;
   assign iic.word_addr   = word_q;
   assign iic.write_data  = data_q;
   assign O_busy          = (state == S_FETCH_ADDR) || (state == S_FETCH_DATA) ||
                            (state == S_SEND) || (state == S_GAP);

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state       <= S_IDLE;
         index       <= '0;
         retry       <= '0;
         cnt         <= '0;
         O_rom_addr  <= '0;
         word_q      <= '0;
         data_q      <= '0;
         O_cfg_done  <= 1'b0;
         O_cfg_err   <= 1'b0;
         O_err_index <= '0;
      end else begin
         state       <= state_nxt;
         index       <= index_nxt;
         retry       <= retry_nxt;
         cnt         <= cnt_nxt;
         O_rom_addr  <= rom_addr_nxt;
         word_q      <= word_nxt;
         data_q      <= data_nxt;
         O_cfg_done  <= cfg_done_nxt;
         O_cfg_err   <= cfg_err_nxt;
         O_err_index <= err_index_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      index_nxt     = index;
      retry_nxt     = retry;
      cnt_nxt       = '0;
      rom_addr_nxt  = O_rom_addr;
      word_nxt      = word_q;
      data_nxt      = data_q;
      cfg_done_nxt  = O_cfg_done;
      cfg_err_nxt   = O_cfg_err;
      err_index_nxt = O_err_index;
      case (state)
         // DONE/ERR last one cycle with busy low, so a start there is honoured like in IDLE.
         S_IDLE, S_DONE, S_ERR: begin
            state_nxt = S_IDLE;
            if (I_start) begin
               cfg_done_nxt = 1'b0;
               cfg_err_nxt  = 1'b0;
               index_nxt    = '0;
               retry_nxt    = '0;
               rom_addr_nxt = '0;
               if (C_REG_NUM == 8'd0) begin
                  state_nxt    = S_DONE;
                  cfg_done_nxt = 1'b1;
               end else begin
                  state_nxt = S_FETCH_ADDR;
               end
            end
         end
         S_FETCH_ADDR: state_nxt = S_FETCH_DATA;
         S_FETCH_DATA: begin
            word_nxt  = I_rom_data[15:8];
            data_nxt  = I_rom_data[7:0];
            state_nxt = S_SEND;
         end
         S_SEND: begin
            cnt_nxt = cnt + 32'd1;
            if (iic.iic_done) begin
               cnt_nxt   = '0;
               retry_nxt = '0;
               index_nxt = index + 9'd1;
               state_nxt = S_GAP;
            end else if (cnt == C_TIMEOUT - 32'd1) begin
               cnt_nxt   = '0;
               retry_nxt = retry + 4'd1;
               if (retry + 4'd1 == C_RETRY_MAX) begin
                  state_nxt     = S_ERR;
                  cfg_err_nxt   = 1'b1;
                  err_index_nxt = index[7:0];
               end else begin
                  state_nxt = S_GAP;
               end
            end
         end
         S_GAP: begin
            cnt_nxt = cnt + 32'd1;
            if (cnt + 32'd1 >= {16'd0, C_GAP_CYCLES}) begin
               cnt_nxt = '0;
               if (index == {1'b0, C_REG_NUM}) begin
                  state_nxt    = S_DONE;
                  cfg_done_nxt = 1'b1;
               end else if (retry != 4'd0) begin
                  state_nxt = S_SEND;
               end else begin
                  state_nxt    = S_FETCH_ADDR;
                  rom_addr_nxt = index[7:0];
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_iic_cfg_sequencer.sv
// tb/tb_iic_cfg_sequencer.sv - randomized self-checking bench for iic_cfg_sequencer
`timescale 1ns/1ps
module tb_iic_cfg_sequencer;
   localparam int T    = 200;
   localparam int GAP  = 20;
   localparam int MAX  = 3;
   localparam int NREG = 3;
   localparam int TL   = 4096;

   logic        clk = 1'b0;
   logic        rst_n, start, start0;
   logic [7:0]  rom_addr, rom_addr0, err_index, err_index0;
   logic [15:0] rom_data = 16'd0;
   logic [15:0] rom_data0 = 16'd0;
   logic        busy, cfg_done, cfg_err, busy0, cfg_done0, cfg_err0;

   iic_cfg_sequencer_if iic();
   iic_cfg_sequencer_if iic0();

   iic_cfg_sequencer #(.C_DEV_ADDR(7'h21), .C_REG_NUM(8'd3), .C_TIMEOUT(32'd200),
                       .C_RETRY_MAX(4'd3), .C_GAP_CYCLES(16'd20)) dut (
      .I_clk(clk), .I_rst_n(rst_n), .I_start(start), .O_rom_addr(rom_addr),
      .I_rom_data(rom_data), .iic(iic), .O_busy(busy), .O_cfg_done(cfg_done),
      .O_cfg_err(cfg_err), .O_err_index(err_index));

   iic_cfg_sequencer #(.C_DEV_ADDR(7'h21), .C_REG_NUM(8'd0), .C_TIMEOUT(32'd200),
                       .C_RETRY_MAX(4'd3), .C_GAP_CYCLES(16'd20)) dut0 (
      .I_clk(clk), .I_rst_n(rst_n), .I_start(start0), .O_rom_addr(rom_addr0),
      .I_rom_data(rom_data0), .iic(iic0), .O_busy(busy0), .O_cfg_done(cfg_done0),
      .O_cfg_err(cfg_err0), .O_err_index(err_index0));

   always #5 clk = ~clk;

   logic [15:0] rom_mem [256];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   int n_checks, n_fail;
   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (time %0t)", name, act, exp, $time);
      end
   endfunction

   // Expected per-cycle trace, index = cycles after the edge that accepts start.
   logic       exp_en[TL], exp_busy[TL], exp_done[TL], exp_err[TL], exp_fetch[TL];
   logic [7:0] exp_word[TL], exp_data[TL], exp_rom[TL], exp_eidx[TL];
   int n_t, exp_last;
   int nacks[NREG];
   int acklat[NREG];
   int lat_q[$];

   task automatic push(input logic en, input logic bz, input logic dn, input logic er,
                       input logic [7:0] w, input logic [7:0] d, input logic f,
                       input logic [7:0] ra, input logic [7:0] ei);
      if (n_t < TL) begin
         exp_en[n_t] = en; exp_busy[n_t] = bz; exp_done[n_t] = dn; exp_err[n_t] = er;
         exp_word[n_t] = w; exp_data[n_t] = d; exp_fetch[n_t] = f; exp_rom[n_t] = ra;
         exp_eidx[n_t] = ei;
      end
      n_t++;
   endtask

   task automatic build_model();
      logic [15:0] e;
      n_t = 1;
      lat_q.delete();
      for (int i = 0; i < NREG; i++) begin
         e = rom_mem[i];
         push(0, 1, 0, 0, 8'h0, 8'h0, 1, 8'(i), 8'h0);
         push(0, 1, 0, 0, 8'h0, 8'h0, 0, 8'h0, 8'h0);
         for (int a = 0; a <= nacks[i] && a < MAX; a++) begin
            bit nack;
            int len;
            nack = (a < nacks[i]);
            len  = nack ? T : acklat[i];
            lat_q.push_back(nack ? 0 : acklat[i]);
            for (int c = 0; c < len; c++) push(1, 1, 0, 0, e[15:8], e[7:0], 0, 8'h0, 8'h0);
            if (nack && a + 1 == MAX) begin
               push(0, 0, 0, 1, 8'h0, 8'h0, 0, 8'h0, 8'(i));
               exp_last = n_t - 1;
               return;
            end
            for (int c = 0; c < GAP; c++) push(0, 1, 0, 0, 8'h0, 8'h0, 0, 8'h0, 8'h0);
         end
      end
      push(0, 0, 1, 0, 8'h0, 8'h0, 0, 8'h0, 8'h0);
      exp_last = n_t - 1;
   endtask

   // iic_send stand-in: pulses done on the planned cycle of each attempt, plus stray pulses while idle.
   bit stray_done;
   initial begin
      int k, cur_lat;
      k = 0; cur_lat = 0;
      iic.iic_done  = 1'b0;
      iic0.iic_done = 1'b0;
      forever begin
         @(negedge clk);
         if (iic.iic_send_en) begin
            if (k == 0) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            k++;
            iic.iic_done = (cur_lat != 0) && (k == cur_lat);
         end else begin
            k = 0;
            iic.iic_done = stray_done && ($urandom_range(0, 15) == 0);
         end
      end
   end

   bit         armed;
   int         tcur, obs_done_t;
   logic [7:0] obs_words[$];
   logic       prev_en, prev_done;
   bit         en0_seen;
   initial begin
      tcur = 0; obs_done_t = -1; prev_en = 0; prev_done = 0; en0_seen = 0;
      forever begin
         @(negedge clk);
         if (!armed) begin
            tcur = 0;
            obs_done_t = -1;
            obs_words.delete();
         end else begin
            int ti;
            tcur++;
            ti = (tcur > exp_last) ? exp_last : tcur;
            chk("send_en", 32'(iic.iic_send_en), 32'(exp_en[ti]));
            chk("busy", 32'(busy), 32'(exp_busy[ti]));
            chk("cfg_done", 32'(cfg_done), 32'(exp_done[ti]));
            chk("cfg_err", 32'(cfg_err), 32'(exp_err[ti]));
            chk("dev_addr", 32'(iic.dev_addr), 32'h21);
            if (exp_en[ti]) begin
               chk("word_addr", 32'(iic.word_addr), 32'(exp_word[ti]));
               chk("write_data", 32'(iic.write_data), 32'(exp_data[ti]));
            end
            if (exp_fetch[ti]) chk("rom_addr", 32'(rom_addr), 32'(exp_rom[ti]));
            if (exp_err[ti]) chk("err_index", 32'(err_index), 32'(exp_eidx[ti]));
            if (iic.iic_send_en && !prev_en) obs_words.push_back(iic.word_addr);
            if (cfg_done && !prev_done) obs_done_t = tcur;
         end
         prev_en = iic.iic_send_en;
         prev_done = cfg_done;
         if (iic0.iic_send_en) en0_seen = 1;
      end
   end

   task automatic run(input bit strays);
      build_model();
      @(posedge clk); #2; start = 1'b1;
      @(posedge clk); #2; start = 1'b0; armed = 1;
      for (int c = 0; c < 6000 && tcur < exp_last + 4; c++) begin
         @(posedge clk); #2;
         start = 1'b0;
         if (strays && tcur + 1 < exp_last && exp_busy[tcur + 1] && $urandom_range(0, 15) == 0)
            start = 1'b1;
      end
      start = 1'b0;
      chk("run_complete", 32'(tcur >= exp_last + 4), 32'd1);
      armed = 0;
   endtask

   task automatic check_words(input string nm, input logic [7:0] wq[$]);
      chk({nm, "_count"}, 32'(obs_words.size()), 32'(wq.size()));
      for (int i = 0; i < wq.size() && i < obs_words.size(); i++)
         chk(nm, 32'(obs_words[i]), 32'(wq[i]));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] wq[$];
      n_checks = 0; n_fail = 0; armed = 0; stray_done = 0;
      rst_n = 1'b0; start = 1'b0; start0 = 1'b0;
      for (int i = 0; i < 256; i++) rom_mem[i] = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst_en", 32'(iic.iic_send_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(cfg_done), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);
      chk("rst_err_index", 32'(err_index), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_word", 32'({iic.word_addr, iic.write_data}), 32'd0);
      chk("rst_dev_addr", 32'(iic.dev_addr), 32'h21);
      @(posedge clk); #2; rst_n = 1'b1;

      // Empty table: done straight away, no transfer.
      @(posedge clk); #2; start0 = 1'b1;
      @(posedge clk); #2; start0 = 1'b0;
      @(negedge clk);
      chk("zero_done", 32'(cfg_done0), 32'd1);
      chk("zero_busy", 32'(busy0), 32'd0);

      // Three ACKed transfers with fixed latency.
      rom_mem[0] = 16'h1234; rom_mem[1] = 16'h5678; rom_mem[2] = 16'h9ABC;
      nacks = '{0, 0, 0}; acklat = '{5, 5, 5};
      run(0);
      wq = {8'h12, 8'h56, 8'h9A};
      check_words("t1_words", wq);
      chk("t1_done_cycle", 32'(obs_done_t), 32'd82);

      // Entry 1 NACKs once.
      nacks = '{0, 1, 0}; acklat = '{int'($urandom_range(1, T - 1)), 7, 3};
      run(0);
      wq = {8'h12, 8'h56, 8'h56, 8'h9A};
      check_words("t2_words", wq);
      chk("t2_done", 32'(cfg_done), 32'd1);
      chk("t2_err", 32'(cfg_err), 32'd0);

      // Entry 2 never completes.
      stray_done = 1;
      nacks = '{0, 0, 3}; acklat = '{4, 9, 1};
      run(1);
      chk("t3_attempts", 32'(obs_words.size()), 32'd5);
      chk("t3_err", 32'(cfg_err), 32'd1);
      chk("t3_err_index", 32'(err_index), 32'd2);
      chk("t3_done", 32'(cfg_done), 32'd0);

      // Done coinciding with the timeout cycle counts as success.
      nacks = '{0, 0, 0}; acklat = '{T, 1, T};
      run(1);
      chk("t4_done", 32'(cfg_done), 32'd1);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NREG; i++) begin
            int w;
            rom_mem[i] = 16'($urandom);
            w = int'($urandom_range(0, 9));
            nacks[i]  = (w < 6) ? 0 : (w < 8) ? 1 : (w < 9) ? 2 : 3;
            acklat[i] = int'($urandom_range(1, T));
         end
         run(1);
      end

      // Reset in the middle of a transfer, then a clean rerun.
      nacks = '{0, 0, 0}; acklat = '{T - 1, T - 1, T - 1};
      build_model();
      @(posedge clk); #2; start = 1'b1;
      @(posedge clk); #2; start = 1'b0;
      for (int c = 0; c < 50 && !iic.iic_send_en; c++) begin
         @(posedge clk); #2;
      end
      chk("rst_mid_reached_send", 32'(iic.iic_send_en), 32'd1);
      repeat (10) begin @(posedge clk); #2; end
      rst_n = 1'b0;
      #1;
      chk("rst_mid_en", 32'(iic.iic_send_en), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(cfg_done), 32'd0);
      chk("rst_mid_err", 32'(cfg_err), 32'd0);
      repeat (3) @(posedge clk);
      #2; rst_n = 1'b1;
      for (int i = 0; i < NREG; i++) acklat[i] = int'($urandom_range(1, 20));
      run(1);
      chk("rst_rerun_done", 32'(cfg_done), 32'd1);
      chk("rst_rerun_words", 32'(obs_words.size()), 32'd3);

      chk("zero_en_never", 32'(en0_seen), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
